// File: rtl/cde_jtag_rpc_master.sv
// cde_jtag_rpc_master
// Bus-master controller behind the TAP's RPC_ADD / RPC_DATA instructions.
// It owns two DR chains. The address/command chain {auto_inc, wr, addr} sits
// on addr_select_i. The data/status chain {err, busy, data} sits on
// data_select_i. Update events on these chains launch single read or write
// transfers on a synchronous req/ack bus. The controller supports address
// auto-increment and an ack timeout. Everything runs on jtag_clk.
//
// Ports:
//   jtag_clk, trst_n_pad_in        clock, async active-low reset
//   test_logic_reset_i             TAP in Test-Logic-Reset (sync abort)
//   capture_dr_i/shift_dr_i/update_dr_i, tdi_i   TAP DR controls
//   addr_select_i, data_select_i   RPC_ADD / RPC_DATA instruction active
//   addr_tdo_o, data_tdo_o         chain LSBs (combinational)
//   bus_req_o, bus_wr_o, bus_addr_o, bus_wdata_o  request side of the bus
//   bus_rdata_i, bus_ack_i         completion side of the bus
//   busy_o                         transfer in flight
module cde_jtag_rpc_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              jtag_clk,
    input  logic              trst_n_pad_in,
    input  logic              test_logic_reset_i,
    input  logic              capture_dr_i,
    input  logic              shift_dr_i,
    input  logic              update_dr_i,
    input  logic              tdi_i,
    input  logic              addr_select_i,
    input  logic              data_select_i,
    output logic              addr_tdo_o,
    output logic              data_tdo_o,
    output logic              bus_req_o,
    output logic              bus_wr_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_t;

    localparam logic [7:0]        TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W+1:0] addr_chain;
    logic [DATA_W+1:0] data_chain;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;
    logic              auto_inc_r;
    logic              wr_r;
    logic              err_r;
    logic [7:0]        tmo_cnt;

    logic              idle;
    logic              addr_upd;
    logic              data_upd;
    logic              launch;
    logic              launch_wr;
    logic [ADDR_W-1:0] launch_addr;
    logic              start;
    logic              overrun;
    logic              timeout_hit;

    assign idle        = (state == ST_IDLE);
    assign busy_o      = ~idle;
    assign addr_upd    = update_dr_i & addr_select_i;
    assign data_upd    = update_dr_i & data_select_i & ~addr_select_i;
    assign addr_tdo_o  = addr_chain[0];
    assign data_tdo_o  = data_chain[0];
    assign bus_wdata_o = wdata_r;

    // Decode a launch request from the update events. An address update
    // launches a read only when its wr bit is 0, and it uses the freshly
    // shifted address because addr_r is only written on this same edge.
    always_comb begin
        launch      = 1'b0;
        launch_wr   = 1'b0;
        launch_addr = addr_r;
        if (addr_upd) begin
            launch      = ~addr_chain[ADDR_W];
            launch_addr = addr_chain[ADDR_W-1:0];
        end else if (data_upd) begin
            launch    = 1'b1;
            launch_wr = wr_r;
        end
    end

    assign start       = launch & idle;
    assign overrun     = launch & ~idle;
    assign timeout_hit = ~idle & ~bus_ack_i & (tmo_cnt == TMO_LAST);

    // The two DR chains. Capture snapshots the live registers, and shift
    // moves right with tdi_i entering at the MSB. With neither select
    // active, the chains hold their contents.
    always_ff @(posedge jtag_clk or negedge trst_n_pad_in) begin
        if (!trst_n_pad_in) begin
            addr_chain <= '0;
            data_chain <= '0;
        end else begin
            if (addr_select_i) begin
                if (capture_dr_i)
                    addr_chain <= {auto_inc_r, wr_r, addr_r};
                else if (shift_dr_i)
                    addr_chain <= {tdi_i, addr_chain[ADDR_W+1:1]};
            end
            if (data_select_i) begin
                if (capture_dr_i)
                    data_chain <= {err_r, busy_o, rdata_r};
                else if (shift_dr_i)
                    data_chain <= {tdi_i, data_chain[DATA_W+1:1]};
            end
        end
    end

    // Transaction sequencer. Test-Logic-Reset aborts any transfer but
    // keeps the address, data and mode registers. A launch while busy is
    // dropped and flagged in err_r. An abort or overrun on the same edge
    // as an address update beats that update's err clear. If an address
    // update lands on the ack edge, the newly latched address wins over
    // the auto-increment.
    always_ff @(posedge jtag_clk or negedge trst_n_pad_in) begin
        if (!trst_n_pad_in) begin
            state      <= ST_IDLE;
            bus_req_o  <= 1'b0;
            bus_wr_o   <= 1'b0;
            bus_addr_o <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            rdata_r    <= '0;
            auto_inc_r <= 1'b0;
            wr_r       <= 1'b0;
            err_r      <= 1'b0;
            tmo_cnt    <= '0;
        end else if (test_logic_reset_i) begin
            state     <= ST_IDLE;
            bus_req_o <= 1'b0;
            err_r     <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            if (addr_upd) begin
                auto_inc_r <= addr_chain[ADDR_W+1];
                wr_r       <= addr_chain[ADDR_W];
                addr_r     <= addr_chain[ADDR_W-1:0];
            end
            if (data_upd && wr_r && idle)
                wdata_r <= data_chain[DATA_W-1:0];

            if (overrun || timeout_hit)
                err_r <= 1'b1;
            else if (addr_upd)
                err_r <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= launch_wr ? ST_WR : ST_RD;
                        bus_req_o  <= 1'b1;
                        bus_wr_o   <= launch_wr;
                        bus_addr_o <= launch_addr;
                        tmo_cnt    <= '0;
                    end
                end
                default: begin
                    if (bus_ack_i) begin
                        state     <= ST_IDLE;
                        bus_req_o <= 1'b0;
                        tmo_cnt   <= '0;
                        if (state == ST_RD)
                            rdata_r <= bus_rdata_i;
                        if (auto_inc_r && !addr_upd)
                            addr_r <= addr_r + ADDR_ONE;
                    end else if (timeout_hit) begin
                        state     <= ST_IDLE;
                        bus_req_o <= 1'b0;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cde_jtag_rpc_master.sv
// tb_cde_jtag_rpc_master
// Self-checking bench for cde_jtag_rpc_master (TIMEOUT = 4).
// A table of scan vectors drives DR captures, shifts and updates.
// A bus responder / monitor process acts as the slave. Expected bus
// requests are queued when a launch is driven and are popped and compared
// when the request rises. Hand-written sequences cover overrun,
// Test-Logic-Reset abort and async reset.
module tb_cde_jtag_rpc_master;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int TMO    = 4;

    logic              jtag_clk           = 1'b0;
    logic              trst_n_pad_in      = 1'b0;
    logic              test_logic_reset_i = 1'b0;
    logic              capture_dr_i       = 1'b0;
    logic              shift_dr_i         = 1'b0;
    logic              update_dr_i        = 1'b0;
    logic              tdi_i              = 1'b0;
    logic              addr_select_i      = 1'b0;
    logic              data_select_i      = 1'b0;
    logic              addr_tdo_o;
    logic              data_tdo_o;
    logic              bus_req_o;
    logic              bus_wr_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic [DATA_W-1:0] bus_rdata_i;
    logic              bus_ack_i;
    logic              busy_o;

    logic              auto_ack  = 1'b0;
    logic              stray_ack = 1'b0;
    logic [DATA_W-1:0] rdata_val = '0;
    int                ack_delay = 0;
    int                last_len  = 0;
    int                checks    = 0;
    int                errors    = 0;

    assign bus_ack_i   = auto_ack | stray_ack;
    assign bus_rdata_i = rdata_val;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
    } bus_txn_t;

    typedef struct {
        bit          sel_addr;
        bit          do_upd;
        logic [33:0] din;
        int          ack_dly;
        logic [31:0] rdata;
        bit          launch;
        logic        exp_wr;
        logic [15:0] exp_addr;
        logic [31:0] exp_wdata;
        int          exp_len;
        int          cap_sel;
        logic [33:0] exp_cap;
    } vec_t;

    bus_txn_t exp_q[$];
    vec_t     vecs[8];

    cde_jtag_rpc_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TMO)
    ) dut (
        .jtag_clk          (jtag_clk),
        .trst_n_pad_in     (trst_n_pad_in),
        .test_logic_reset_i(test_logic_reset_i),
        .capture_dr_i      (capture_dr_i),
        .shift_dr_i        (shift_dr_i),
        .update_dr_i       (update_dr_i),
        .tdi_i             (tdi_i),
        .addr_select_i     (addr_select_i),
        .data_select_i     (data_select_i),
        .addr_tdo_o        (addr_tdo_o),
        .data_tdo_o        (data_tdo_o),
        .bus_req_o         (bus_req_o),
        .bus_wr_o          (bus_wr_o),
        .bus_addr_o        (bus_addr_o),
        .bus_wdata_o       (bus_wdata_o),
        .bus_rdata_i       (bus_rdata_i),
        .bus_ack_i         (bus_ack_i),
        .busy_o            (busy_o)
    );

    // 100 MHz TCK-style clock.
    always #5 jtag_clk = ~jtag_clk;

    function automatic logic [33:0] achain(input logic ai, input logic wr, input logic [15:0] a);
        return {16'b0, ai, wr, a};
    endfunction

    function automatic logic [33:0] dchain(input logic err, input logic busy, input logic [31:0] d);
        return {err, busy, d};
    endfunction

    // Single comparison point; every mismatch reports one FAIL line.
    task automatic checkOutput(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    // One full DR scan: capture, shift len bits (collecting tdo), optional update.
    // Returns on the falling edge after the update edge, with controls released.
    task automatic scan_dr(input bit sel_addr, input logic [33:0] din, input bit do_upd,
                           output logic [33:0] dout);
        int len;
        len  = sel_addr ? ADDR_W + 2 : DATA_W + 2;
        dout = '0;
        @(negedge jtag_clk);
        addr_select_i = sel_addr;
        data_select_i = !sel_addr;
        capture_dr_i  = 1'b1;
        @(negedge jtag_clk);
        capture_dr_i = 1'b0;
        shift_dr_i   = 1'b1;
        for (int i = 0; i < len; i++) begin
            dout[i] = sel_addr ? addr_tdo_o : data_tdo_o;
            tdi_i   = din[i];
            @(negedge jtag_clk);
        end
        shift_dr_i  = 1'b0;
        update_dr_i = do_upd;
        @(negedge jtag_clk);
        update_dr_i   = 1'b0;
        addr_select_i = 1'b0;
        data_select_i = 1'b0;
    endtask

    task automatic capture(input bit sel_addr, output logic [33:0] val);
        scan_dr(sel_addr, '0, 1'b0, val);
    endtask

    // Bounded wait for the controller to return to idle, plus one settling cycle.
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 100) begin
            @(negedge jtag_clk);
            n++;
        end
        checkOutput({tag, "_idle"}, 34'(busy_o), 34'd0);
        @(negedge jtag_clk);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [33:0] dummy;
        logic [33:0] cap;
        bus_txn_t    t;
        ack_delay = v.ack_dly;
        rdata_val = v.rdata;
        if (v.launch) begin
            t.wr    = v.exp_wr;
            t.addr  = v.exp_addr;
            t.wdata = v.exp_wdata;
            exp_q.push_back(t);
        end
        scan_dr(v.sel_addr, v.din, v.do_upd, dummy);
        if (v.launch) begin
            checkOutput($sformatf("v%0d_busy_at_launch", idx), 34'(busy_o), 34'd1);
            checkOutput($sformatf("v%0d_req_at_launch", idx), 34'(bus_req_o), 34'd1);
        end
        wait_idle($sformatf("v%0d", idx));
        if (v.launch)
            checkOutput($sformatf("v%0d_req_len", idx), 34'(last_len), 34'(v.exp_len));
        checkOutput($sformatf("v%0d_sb_empty", idx), 34'(exp_q.size()), 34'd0);
        if (v.cap_sel != 0) begin
            capture(v.cap_sel == 1, cap);
            checkOutput($sformatf("v%0d_capture", idx), cap, v.exp_cap);
        end
    endtask

    // Bus slave and request monitor: pops the expected request on each
    // rising req and acks after ack_delay request cycles (0 = never).
    initial begin : responder
        bus_txn_t t;
        int       req_cycles;
        logic     prev_req;
        req_cycles = 0;
        prev_req   = 1'b0;
        forever begin
            @(negedge jtag_clk);
            if (bus_req_o) begin
                if (!prev_req) begin
                    checkOutput("sb_pending", 34'(exp_q.size() > 0), 34'd1);
                    if (exp_q.size() > 0) begin
                        t = exp_q.pop_front();
                        checkOutput("bus_wr", 34'(bus_wr_o), 34'(t.wr));
                        checkOutput("bus_addr", 34'(bus_addr_o), 34'(t.addr));
                        if (t.wr)
                            checkOutput("bus_wdata", 34'(bus_wdata_o), 34'(t.wdata));
                    end
                    req_cycles = 0;
                end
                req_cycles++;
                auto_ack = (ack_delay != 0) && (req_cycles == ack_delay);
            end else begin
                if (prev_req)
                    last_len = req_cycles;
                auto_ack = 1'b0;
            end
            prev_req = bus_req_o;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [33:0] cap;
        logic [33:0] dummy;
        bus_txn_t    t;

        vecs[0] = '{1'b1, 1'b1, achain(1'b0, 1'b0, 16'h1234), 3, 32'hDEADBEEF,
                    1'b1, 1'b0, 16'h1234, 32'h0, 3, 2, dchain(1'b0, 1'b0, 32'hDEADBEEF)};
        vecs[1] = '{1'b1, 1'b1, achain(1'b1, 1'b1, 16'h00FF), 0, 32'h0,
                    1'b0, 1'b0, 16'h0, 32'h0, 0, 0, 34'h0};
        vecs[2] = '{1'b0, 1'b1, dchain(1'b0, 1'b0, 32'h11111111), 1, 32'h0,
                    1'b1, 1'b1, 16'h00FF, 32'h11111111, 1, 0, 34'h0};
        vecs[3] = '{1'b0, 1'b1, dchain(1'b0, 1'b0, 32'h22222222), 1, 32'h0,
                    1'b1, 1'b1, 16'h0100, 32'h22222222, 1, 1, achain(1'b1, 1'b1, 16'h0101)};
        vecs[4] = '{1'b1, 1'b1, achain(1'b1, 1'b0, 16'hFFFF), 2, 32'hCAFEF00D,
                    1'b1, 1'b0, 16'hFFFF, 32'h0, 2, 1, achain(1'b1, 1'b0, 16'h0000)};
        vecs[5] = '{1'b0, 1'b1, dchain(1'b0, 1'b0, 32'h99999999), 0, 32'h0,
                    1'b1, 1'b0, 16'h0000, 32'h0, TMO, 2, dchain(1'b1, 1'b0, 32'hCAFEF00D)};
        vecs[6] = '{1'b1, 1'b0, achain(1'b0, 1'b0, 16'h0000), 0, 32'h0,
                    1'b0, 1'b0, 16'h0, 32'h0, 0, 1, achain(1'b1, 1'b0, 16'h0000)};
        vecs[7] = '{1'b1, 1'b1, achain(1'b0, 1'b1, 16'h0200), 0, 32'h0,
                    1'b0, 1'b0, 16'h0, 32'h0, 0, 2, dchain(1'b0, 1'b0, 32'hCAFEF00D)};

        // Reset state.
        repeat (2) @(negedge jtag_clk);
        checkOutput("rst_req", 34'(bus_req_o), 34'd0);
        checkOutput("rst_wr", 34'(bus_wr_o), 34'd0);
        checkOutput("rst_addr", 34'(bus_addr_o), 34'd0);
        checkOutput("rst_wdata", 34'(bus_wdata_o), 34'd0);
        checkOutput("rst_busy", 34'(busy_o), 34'd0);
        checkOutput("rst_tdo", 34'({addr_tdo_o, data_tdo_o}), 34'd0);
        trst_n_pad_in = 1'b1;
        @(negedge jtag_clk);

        for (int i = 0; i < 8; i++)
            applyStimulus(vecs[i], i);

        // Overrun: a second data update while the write is outstanding.
        ack_delay = 3;
        t = '{1'b1, 16'h0200, 32'hAAAAAAAA};
        exp_q.push_back(t);
        scan_dr(1'b0, dchain(1'b0, 1'b0, 32'hAAAAAAAA), 1'b1, dummy);
        data_select_i = 1'b1;
        shift_dr_i    = 1'b1;
        tdi_i         = 1'b0;
        @(negedge jtag_clk);
        shift_dr_i  = 1'b0;
        update_dr_i = 1'b1;
        @(negedge jtag_clk);
        update_dr_i   = 1'b0;
        data_select_i = 1'b0;
        wait_idle("ovr");
        checkOutput("ovr_req_len", 34'(last_len), 34'd3);
        checkOutput("ovr_wdata_kept", 34'(bus_wdata_o), 34'(32'hAAAAAAAA));
        checkOutput("ovr_sb_empty", 34'(exp_q.size()), 34'd0);
        capture(1'b0, cap);
        checkOutput("ovr_err_set", cap, dchain(1'b1, 1'b0, 32'hCAFEF00D));
        scan_dr(1'b1, achain(1'b0, 1'b1, 16'h0200), 1'b1, dummy);
        capture(1'b0, cap);
        checkOutput("ovr_err_clr", cap, dchain(1'b0, 1'b0, 32'hCAFEF00D));

        // Test-Logic-Reset during a read, then a stray ack while idle.
        ack_delay = 0;
        t = '{1'b0, 16'h0300, 32'h0};
        exp_q.push_back(t);
        scan_dr(1'b1, achain(1'b0, 1'b0, 16'h0300), 1'b1, dummy);
        checkOutput("tlr_req_before", 34'(bus_req_o), 34'd1);
        test_logic_reset_i = 1'b1;
        @(negedge jtag_clk);
        checkOutput("tlr_req", 34'(bus_req_o), 34'd0);
        checkOutput("tlr_busy", 34'(busy_o), 34'd0);
        test_logic_reset_i = 1'b0;
        rdata_val          = 32'h12345678;
        stray_ack          = 1'b1;
        @(negedge jtag_clk);
        stray_ack = 1'b0;
        checkOutput("tlr_stray_req", 34'(bus_req_o), 34'd0);
        checkOutput("tlr_stray_busy", 34'(busy_o), 34'd0);
        checkOutput("tlr_sb_empty", 34'(exp_q.size()), 34'd0);
        capture(1'b0, cap);
        checkOutput("tlr_capture", cap, dchain(1'b0, 1'b0, 32'hCAFEF00D));

        // Async reset in the middle of a write.
        scan_dr(1'b1, achain(1'b0, 1'b1, 16'h0400), 1'b1, dummy);
        t = '{1'b1, 16'h0400, 32'h0BADF00D};
        exp_q.push_back(t);
        scan_dr(1'b0, dchain(1'b0, 1'b0, 32'h0BADF00D), 1'b1, dummy);
        checkOutput("arst_req_before", 34'(bus_req_o), 34'd1);
        checkOutput("arst_dtdo_before", 34'(data_tdo_o), 34'd1);
        #2;
        trst_n_pad_in = 1'b0;
        #1;
        checkOutput("arst_req", 34'(bus_req_o), 34'd0);
        checkOutput("arst_wr", 34'(bus_wr_o), 34'd0);
        checkOutput("arst_addr", 34'(bus_addr_o), 34'd0);
        checkOutput("arst_wdata", 34'(bus_wdata_o), 34'd0);
        checkOutput("arst_busy", 34'(busy_o), 34'd0);
        checkOutput("arst_tdo", 34'({addr_tdo_o, data_tdo_o}), 34'd0);
        @(negedge jtag_clk);
        trst_n_pad_in = 1'b1;
        checkOutput("arst_sb_empty", 34'(exp_q.size()), 34'd0);
        capture(1'b1, cap);
        checkOutput("arst_addr_chain", cap, achain(1'b0, 1'b0, 16'h0000));
        capture(1'b0, cap);
        checkOutput("arst_data_chain", cap, dchain(1'b0, 1'b0, 32'h0));

        repeat (2) @(negedge jtag_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
